// File: rtl/varredura_origem.sv
// varredura_origem: raster scan of the source image, one RAM read per pixel, handing each
// pixel to the zoom replicator and exporting source coordinates and destination block origin.
module varredura_origem #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        escala,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              rep_enable,
    output logic [7:0]        rep_pixel,
    output logic [2:0]        rep_escala,
    input  logic              rep_done,
    output logic [7:0]        src_x,
    output logic [7:0]        src_y,
    output logic [10:0]       dst_base_x,
    output logic [10:0]       dst_base_y,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, READ, DATA, REP, DONE} state_t;

    localparam logic [7:0] X_LAST = 8'(SRC_W - 1);
    localparam logic [7:0] Y_LAST = 8'(SRC_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        x_q, x_d, y_q, y_d, pix_q, pix_d;
    logic [10:0]       bx_q, bx_d, by_q, by_d;
    logic [2:0]        esc_q, esc_d;
    logic              en_q, en_d, err_q, err_d;
    logic              last_px;

    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        bx_d    = bx_q;
        by_d    = by_q;
        esc_d   = esc_q;
        pix_d   = pix_q;
        en_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (escala != 3'd0) begin
                    esc_d   = escala;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    bx_d    = '0;
                    by_d    = '0;
                    state_d = READ;
                end else begin
                    err_d = 1'b1;
                end
            end
            READ: state_d = DATA;
            DATA: begin
                pix_d   = mem_rdata;
                en_d    = 1'b1;
                state_d = REP;
            end
            REP: if (rep_done) begin
                if (last_px) begin
                    state_d = DONE;
                end else begin
                    // incremental origin update keeps multipliers out of the datapath
                    addr_d  = addr_q + ADDR_W'(1);
                    x_d     = (x_q == X_LAST) ? 8'd0 : x_q + 8'd1;
                    bx_d    = (x_q == X_LAST) ? 11'd0 : bx_q + 11'(esc_q);
                    y_d     = (x_q == X_LAST) ? y_q + 8'd1 : y_q;
                    by_d    = (x_q == X_LAST) ? by_q + 11'(esc_q) : by_q;
                    state_d = READ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            esc_q   <= '0;
            pix_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            esc_q   <= esc_d;
            pix_q   <= pix_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr   = addr_q;
    assign rep_enable = en_q;
    assign rep_pixel  = pix_q;
    assign rep_escala = esc_q;
    assign src_x      = x_q;
    assign src_y      = y_q;
    assign dst_base_x = bx_q;
    assign dst_base_y = by_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign err        = err_q;
endmodule

// File: tb/tb_varredura_origem.sv
// tb_varredura_origem: table-driven and randomized frames against a pixel-sequence reference,
// with replicator and RAM models, plus reject, wrap and mid-frame reset sequences.
module tb_varredura_origem;
    localparam int W = 4, H = 3, AW = 4, NPIX = W * H;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, rep_done = 1'b0;
    logic [2:0]    escala = 3'd0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0, rep_pixel, src_x, src_y;
    logic          rep_enable, busy, frame_done, err;
    logic [2:0]    rep_escala;
    logic [10:0]   dst_base_x, dst_base_y;

    varredura_origem #(.SRC_W(W), .SRC_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .escala(escala), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .rep_enable(rep_enable), .rep_pixel(rep_pixel),
        .rep_escala(rep_escala), .rep_done(rep_done), .src_x(src_x), .src_y(src_y),
        .dst_base_x(dst_base_x), .dst_base_y(dst_base_y), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] ram [16];
    int rep_delay = 5, spur = 0, exp_esc = 0, pix_idx = 0, en_cnt = 0, fd_cnt = 0;
    int pend = 0, cnt_rd = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    // replicator: done is visible rep_delay cycles after the enable cycle
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            rep_done = 1'b0;
        end else begin
            if (rep_enable) begin
                pend = 1;
                cnt_rd = rep_delay;
            end
            if (pend != 0) begin
                if (cnt_rd == 0) begin
                    rep_done = 1'b1;
                    pend = 0;
                end else begin
                    rep_done = 1'b0;
                    cnt_rd--;
                end
            end else rep_done = (spur != 0);
        end
    end

    // every handed-off pixel must be the next one in raster order
    always @(negedge clk) begin
        if (!rst && rep_enable) begin
            en_cnt++;
            if (pix_idx < NPIX) begin
                check("pixel", rep_pixel, ram[pix_idx]);
                check("src_x", src_x, pix_idx % W);
                check("src_y", src_y, pix_idx / W);
                check("dst_x", dst_base_x, (pix_idx % W) * exp_esc);
                check("dst_y", dst_base_y, (pix_idx / W) * exp_esc);
                check("addr", mem_addr, pix_idx);
                check("rep_escala", rep_escala, exp_esc);
            end else check("extra_enable", pix_idx, NPIX - 1);
            pix_idx++;
        end
        if (!rst && frame_done) fd_cnt++;
    end

    task automatic prep(input int esc, input int d, input int sp, input bit ramp);
        for (int i = 0; i < 16; i++) ram[i] = ramp ? 8'(i) : 8'($urandom);
        rep_delay = d;
        spur = sp;
        exp_esc = esc;
        pix_idx = 0;
    endtask

    task automatic run_frame(input int esc, input int d, input int sp, input int meddle,
                             input int exp_len, input bit ramp);
        int cnt;
        prep(esc, d, sp, ramp);
        @(negedge clk);
        start = 1'b1;
        escala = 3'(esc);
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        while (!frame_done && cnt < 4000) begin
            if (meddle != 0) begin
                start = 1'($urandom);
                escala = 3'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check("frame_len", cnt, exp_len);
        check("pixel_count", pix_idx, NPIX);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("fd_pulse", frame_done, 0);
        check("hold_src", {src_y, src_x}, {8'(H - 1), 8'(W - 1)});
        check("hold_dst", {dst_base_y, dst_base_x}, {11'((H - 1) * esc), 11'((W - 1) * esc)});
    endtask

    typedef struct {
        int esc;
        int d;
        int sp;
        int meddle;
        int exp_len;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base_en, base_fd, t, e, d;
        vecs[0] = '{2, 5, 0, 0, 97};
        vecs[1] = '{3, 10, 0, 0, 157};
        vecs[2] = '{1, 2, 1, 0, 61};
        vecs[3] = '{7, 50, 0, 1, 637};
        vecs[4] = '{2, 1, 1, 1, 49};
        vecs[5] = '{5, 0, 1, 0, 37};
        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
        repeat (3) @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_enable", rep_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_all", {rep_pixel, rep_escala, src_x, src_y, dst_base_x, dst_base_y,
                          frame_done, err}, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].esc, vecs[i].d, vecs[i].sp, vecs[i].meddle, vecs[i].exp_len, i == 0);

        base_en = en_cnt;
        @(negedge clk);
        escala = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_addr", mem_addr, NPIX - 1);
        @(negedge clk);
        check("err_clear", err, 0);
        repeat (5) @(negedge clk);
        check("err_no_enable", en_cnt, base_en);
        check("err_busy_late", busy, 0);

        prep(2, 5, 0, 0);
        base_en = en_cnt;
        start = 1'b1;
        escala = 3'd2;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (en_cnt < base_en + 6 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reach_px5", en_cnt, base_en + 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {mem_addr, rep_enable, rep_pixel, rep_escala, src_x, src_y,
                                dst_base_x, dst_base_y, busy, frame_done, err}, 0);
        base_en = en_cnt;
        base_fd = fd_cnt;
        repeat (15) @(negedge clk);
        check("abort_no_enable", en_cnt, base_en);
        check("abort_no_fd", fd_cnt, base_fd);
        run_frame(2, 5, 0, 0, 97, 1'b1);

        for (int r = 0; r < 6; r++) begin
            e = $urandom_range(1, 7);
            d = $urandom_range(0, 12);
            run_frame(e, d, $urandom_range(0, 1), $urandom_range(0, 1), NPIX * (d + 3) + 1, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
